uart_hamming_receiver: RTL and testbench



---
 rtl/uart_hamming_receiver.sv | 181 ++++++++++++++++++
 tb/tb_uart_hamming_receiver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hamming_receiver.sv
// ============================================================================
// uart_hamming_receiver: 8N1 UART deserializer with Hamming(7,4) SEC decode
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_hamming_receiver #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic [6:0] code_out,
  output logic       data_valid,
  output logic       err_corrected,
  output logic       pad_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             rx_meta, rxs;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic             cnt_clr;
  logic             bit_sample;
  logic             stop_ok;
  logic             stop_bad;

  logic [2:0]       syndrome;
  logic [6:0]       flip_mask;
  logic [6:0]       fixed_code;

  // Synchronizer preset high so reset looks like an idle line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    bit_sample = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rxs) begin
          state_next = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          if (rxs) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            cnt_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          bit_sample = 1'b1;
          cnt_clr    = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        // Leave mid-stop-bit so a following start edge is not missed
        if (cnt == BIT_LAST) begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
          if (rxs) begin
            stop_ok  = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (state == START) begin
        bit_idx <= 3'd0;
      end else if (bit_sample) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (bit_sample) begin
        shift[bit_idx] <= rxs;
      end
    end
  end

  // Break guard: a held-low line after a framing error must not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (stop_bad) begin
      armed <= 1'b0;
    end else if (state == IDLE && rxs) begin
      armed <= 1'b1;
    end
  end

  always_comb begin
    syndrome[0] = shift[0] ^ shift[2] ^ shift[4] ^ shift[6];
    syndrome[1] = shift[1] ^ shift[2] ^ shift[5] ^ shift[6];
    syndrome[2] = shift[3] ^ shift[4] ^ shift[5] ^ shift[6];
    flip_mask   = (syndrome == 3'd0) ? 7'd0 : (7'd1 << (syndrome - 3'd1));
    fixed_code  = shift[6:0] ^ flip_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= 4'd0;
      code_out      <= 7'd0;
      err_corrected <= 1'b0;
      pad_err       <= 1'b0;
      data_valid    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      data_valid <= stop_ok;
      frame_err  <= stop_bad;
      if (stop_ok) begin
        code_out      <= fixed_code;
        data_out      <= {fixed_code[6], fixed_code[5], fixed_code[4], fixed_code[2]};
        err_corrected <= (syndrome != 3'd0);
        pad_err       <= shift[7];
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_hamming_receiver.sv
// Testbench for uart_hamming_receiver: directed table, corner sequences, random bytes.
`default_nettype none

module tb_uart_hamming_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] data_out;
  logic [6:0] code_out;
  logic       data_valid, err_corrected, pad_err, frame_err, rx_busy;

  uart_hamming_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .data_out(data_out), .code_out(code_out), .data_valid(data_valid),
    .err_corrected(err_corrected), .pad_err(pad_err),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [6:0] c;
    logic       e;
    logic       p;
    int         t;
  } rec_t;

  typedef struct {
    logic [7:0] b;
    int         gap;
    logic [3:0] d;
    logic [6:0] c;
    logic       e;
    logic       p;
  } vec_t;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   fe_cnt = 0;
  int   busy_cnt = 0;
  rec_t got_q[$];
  rec_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) got_q.push_back('{data_out, code_out, err_corrected, pad_err, cyc});
    if (frame_err) fe_cnt++;
    if (rx_busy) busy_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Nearest-codeword search; Hamming(7,4) is perfect so this is exact SEC decoding
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic rec_t model(input logic [7:0] b, input int t);
    rec_t r;
    r = '{4'd0, 7'd0, 1'b0, b[7], t};
    for (int n = 0; n < 16; n++) begin
      if ($countones(enc(4'(n)) ^ b[6:0]) <= 1) begin
        r.d = 4'(n);
        r.c = enc(4'(n));
        r.e = (enc(4'(n)) != b[6:0]);
      end
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge ending the stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop, output int c0);
    c0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // Two sync flops, half-bit start check, nine full bits, one register stage
  function automatic int dv_cycle(input int c0);
    return c0 + 3 + HALF + 9 * CPB;
  endfunction

  task automatic drain();
    rec_t g, e;
    chk("word_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk("data_out", int'(g.d), int'(e.d));
      chk("code_out", int'(g.c), int'(e.c));
      chk("err_corrected", int'(g.e), int'(e.e));
      chk("pad_err", int'(g.p), int'(e.p));
      chk("valid_cycle", g.t, e.t);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int   c0, fe0, b0;
    logic [7:0] rb;

    tbl[0] = '{8'h55, 3, 4'hB, 7'h55, 1'b0, 1'b0};
    tbl[1] = '{8'h45, 3, 4'hB, 7'h55, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 0, 4'h0, 7'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 0, 4'hF, 7'h7F, 1'b0, 1'b0};
    tbl[4] = '{8'hD5, 4, 4'hB, 7'h55, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_code_out", int'(code_out), 0);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_flags", int'({err_corrected, pad_err, frame_err}), 0);
    chk("rst_busy", int'(rx_busy), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed table, last three frames back to back
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].b, 1'b1, c0);
      exp_q.push_back('{tbl[i].d, tbl[i].c, tbl[i].e, tbl[i].p, dv_cycle(c0)});
      rx = 1'b1;
      repeat (tbl[i].gap) @(negedge clk);
    end
    repeat (CPB) @(negedge clk);
    drain();
    chk("hold_data_out", int'(data_out), 4'hB);
    chk("hold_pad_err", int'(pad_err), 1);

    // Framing error followed by a long break, then a clean word
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, c0);
    b0 = busy_cnt;
    repeat (3 * CPB) @(negedge clk);
    chk("break_no_start", busy_cnt - b0, 0);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    send_frame(8'h55, 1'b1, c0);
    exp_q.push_back('{4'hB, 7'h55, 1'b0, 1'b0, dv_cycle(c0)});
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("frame_err_pulses", fe_cnt - fe0, 1);
    drain();

    // Short low glitch: false start only
    fe0 = fe_cnt;
    b0 = busy_cnt;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_busy_seen", int'((busy_cnt - b0) > 0 && (busy_cnt - b0) <= CPB), 1);
    chk("glitch_busy_idle", int'(rx_busy), 0);
    chk("glitch_no_frame_err", fe_cnt - fe0, 0);
    drain();

    // Asynchronous reset during data bit 4; remaining bits are all ones
    fe0 = fe_cnt;
    fork
      send_frame(8'hF0, 1'b1, c0);
      begin
        repeat (5 * CPB + HALF) @(negedge clk);
        #1;
        chk("busy_before_reset", int'(rx_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data_out", int'(data_out), 0);
        chk("async_rst_code_out", int'(code_out), 0);
        chk("async_rst_busy", int'(rx_busy), 0);
        chk("async_rst_flags", int'({data_valid, err_corrected, pad_err, frame_err}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h55, 1'b1, c0);
    exp_q.push_back('{4'hB, 7'h55, 1'b0, 1'b0, dv_cycle(c0)});
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("reset_no_frame_err", fe_cnt - fe0, 0);
    drain();

    // Random bytes with random short gaps (zero gap allowed)
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1, c0);
      exp_q.push_back(model(rb, dv_cycle(c0)));
      rx = 1'b1;
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (CPB) @(negedge clk);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
